// File: rtl/tcam_array_model.sv
`default_nettype none
// ============================================================================
// Module      : tcam_array_model
// Description : Cycle-accurate behavioural model of the 16x8 bit-write TCAM
//               macro. It holds per-word data, care mask and valid bit, and
//               executes one command per cycle from the controller's memory
//               bus: FLUSH > WR > RD > CMP (all gated by CS).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               CS                - chip select (0 = NOP, outputs hold)
//               FLUSH/WR/RD/CMP   - commands
//               VBE, VBI          - valid-bit enable / value (write),
//                                   VBE also enables VBO on read
//               DCS               - 0 = data array, 1 = care array
//               DI, MSKB          - write data + bit-write enable, or
//                                   search key + key care mask
//               A                 - entry address for WR/RD
//               CBE               - bank compare disable (CBE[0]=1 -> miss)
//               DO, VBO           - registered read data / valid
//               HIT, HITLINE      - registered compare result
//               MHIT              - multi-hit flag (only with TCAM_MHIT_EN)
// Options     : `define TCAM_MHIT_EN to add the MHIT output.
// Revision    : 1.0 - initial release
// ============================================================================
module tcam_array_model #(
    parameter int ADDRESS_SIZE = 4,
    parameter int BITS         = 8,
    parameter int WORDS        = 16,
    parameter int BANK_SIZE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CS,
    input  logic                    FLUSH,
    input  logic                    VBE,
    input  logic                    DCS,
    input  logic                    WR,
    input  logic                    RD,
    input  logic                    CMP,
    input  logic [BITS-1:0]         DI,
    input  logic [BITS-1:0]         MSKB,
    input  logic                    VBI,
    input  logic [ADDRESS_SIZE-1:0] A,
    input  logic [BANK_SIZE-1:0]    CBE,
    output logic [BITS-1:0]         DO,
    output logic                    VBO,
    output logic                    HIT,
`ifdef TCAM_MHIT_EN
    output logic                    MHIT,
`endif
    output logic [WORDS-1:0]        HITLINE
);

    localparam logic [ADDRESS_SIZE:0] c_words = (ADDRESS_SIZE + 1)'(WORDS);

    // Storage. Data and care arrays are deliberately not reset: the hard
    // macro keeps their contents across reset, only valid bits clear.
    logic [BITS-1:0]  r_data [WORDS];
    logic [BITS-1:0]  r_care [WORDS];
    logic [WORDS-1:0] r_valid;

    logic [BITS-1:0]  r_do;
    logic             r_vbo;
    logic             r_hit;
    logic [WORDS-1:0] r_hitline;

    // Command decode with fixed priority; exactly one command per cycle.
    logic w_addr_ok;
    logic w_cmd_flush;
    logic w_cmd_wr;
    logic w_cmd_rd;
    logic w_cmd_cmp;

    assign w_addr_ok   = ({1'b0, A} < c_words);
    assign w_cmd_flush = CS & FLUSH;
    assign w_cmd_wr    = CS & ~FLUSH & WR;
    assign w_cmd_rd    = CS & ~FLUSH & ~WR & RD;
    assign w_cmd_cmp   = CS & ~FLUSH & ~WR & ~RD & CMP;

    logic [WORDS-1:0] w_wsel;
    logic [WORDS-1:0] w_hitline;

    generate
        for (genvar i = 0; i < WORDS; i++) begin : g_entry
            localparam logic [ADDRESS_SIZE-1:0] c_idx = ADDRESS_SIZE'(i);

            // Out-of-range writes select no entry and are thereby ignored.
            assign w_wsel[i] = w_cmd_wr & w_addr_ok & (A == c_idx);

            // Bit-write: only bits with MSKB=1 take DI. Reset drops the write.
            always_ff @(posedge clk) begin
                if (!rst && w_wsel[i]) begin
                    if (DCS) begin
                        r_care[i] <= (r_care[i] & ~MSKB) | (DI & MSKB);
                    end else begin
                        r_data[i] <= (r_data[i] & ~MSKB) | (DI & MSKB);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst || w_cmd_flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_wsel[i] && VBE) begin
                    r_valid[i] <= VBI;
                end
            end

            // A bit participates only if both the key and the entry care
            // about it; an entry with care=0 therefore matches any key.
            assign w_hitline[i] = r_valid[i] & ~CBE[0] &
                                  (&(~(MSKB & r_care[i]) | ~(r_data[i] ^ DI)));
        end
    endgenerate

    logic [BITS-1:0] w_rd_data;
    logic            w_rd_valid;

    assign w_rd_data  = w_addr_ok ? (DCS ? r_care[A] : r_data[A]) : '0;
    assign w_rd_valid = w_addr_ok & VBE & r_valid[A];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_do      <= '0;
            r_vbo     <= 1'b0;
            r_hit     <= 1'b0;
            r_hitline <= '0;
        end else if (w_cmd_rd) begin
            r_do      <= w_rd_data;
            r_vbo     <= w_rd_valid;
        end else if (w_cmd_cmp) begin
            r_hitline <= w_hitline;
            r_hit     <= |w_hitline;
        end
    end

`ifdef TCAM_MHIT_EN
    // x & (x-1) clears the lowest set bit; non-zero means two or more hits.
    logic w_mhit;
    logic r_mhit;

    assign w_mhit = |(w_hitline & (w_hitline - WORDS'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mhit <= 1'b0;
        end else if (w_cmd_cmp) begin
            r_mhit <= w_mhit;
        end
    end

    assign MHIT = r_mhit;
`endif

    assign DO      = r_do;
    assign VBO     = r_vbo;
    assign HIT     = r_hit;
    assign HITLINE = r_hitline;

endmodule
`default_nettype wire

// File: tb/tb_tcam_array_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcam_array_model
// Description : Directed self-checking bench for tcam_array_model. A default
//               16-entry instance and a 12-entry instance share all inputs;
//               the latter exercises out-of-range addressing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcam_array_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, flush, vbe, dcs, wr, rd, cmp, vbi;
    logic [7:0] di, mskb;
    logic [3:0] a;
    logic [0:0] cbe;

    logic [7:0]  do0, do1;
    logic        vbo0, vbo1, hit0, hit1;
    logic [15:0] hl0;
    logic [11:0] hl1;
`ifdef TCAM_MHIT_EN
    logic        mhit0, mhit1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcam_array_model dut0 (
        .clk(clk), .rst(rst), .CS(cs), .FLUSH(flush), .VBE(vbe), .DCS(dcs),
        .WR(wr), .RD(rd), .CMP(cmp), .DI(di), .MSKB(mskb), .VBI(vbi), .A(a),
        .CBE(cbe), .DO(do0), .VBO(vbo0), .HIT(hit0),
`ifdef TCAM_MHIT_EN
        .MHIT(mhit0),
`endif
        .HITLINE(hl0)
    );

    tcam_array_model #(.WORDS(12)) dut1 (
        .clk(clk), .rst(rst), .CS(cs), .FLUSH(flush), .VBE(vbe), .DCS(dcs),
        .WR(wr), .RD(rd), .CMP(cmp), .DI(di), .MSKB(mskb), .VBI(vbi), .A(a),
        .CBE(cbe), .DO(do1), .VBO(vbo1), .HIT(hit1),
`ifdef TCAM_MHIT_EN
        .MHIT(mhit1),
`endif
        .HITLINE(hl1)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 0; flush = 0; vbe = 0; dcs = 0; wr = 0; rd = 0; cmp = 0; vbi = 0;
        di = 8'h00; mskb = 8'h00; a = 4'h0; cbe = 1'b0;
    endtask

    task automatic cmd_wr(input logic [3:0] ad, input logic ds, input logic [7:0] d,
                          input logic [7:0] m, input logic ve, input logic vi);
        idle();
        cs = 1; wr = 1; a = ad; dcs = ds; di = d; mskb = m; vbe = ve; vbi = vi;
        tick();
        idle();
    endtask

    task automatic cmd_rd(input logic [3:0] ad, input logic ds, input logic ve);
        idle();
        cs = 1; rd = 1; a = ad; dcs = ds; vbe = ve;
        tick();
        idle();
    endtask

    task automatic cmd_cmp(input logic [7:0] d, input logic [7:0] m, input logic cb);
        idle();
        cs = 1; cmp = 1; di = d; mskb = m; cbe = cb;
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
        // Preload entry 5 and produce non-zero outputs before the reset.
        cmd_wr(4'd5, 1'b0, 8'h33, 8'hFF, 1'b1, 1'b1);
        cmd_wr(4'd5, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        cmd_cmp(8'h33, 8'hFF, 1'b0);
        checks++; if (hl0 !== 16'h0020) begin failures++; $display("FAIL pre_reset_hitline got=%h exp=0020", hl0); end
        cmd_rd(4'd5, 1'b0, 1'b1);
        checks++; if (do0 !== 8'h33 || vbo0 !== 1'b1) begin failures++; $display("FAIL pre_reset_rd got=%h/%b exp=33/1", do0, vbo0); end
        rst = 1; tick(); rst = 0;
        checks++; if (do0 !== 8'h00 || vbo0 !== 1'b0) begin failures++; $display("FAIL reset_do_vbo got=%h/%b exp=00/0", do0, vbo0); end
        checks++; if (hit0 !== 1'b0 || hl0 !== 16'h0000) begin failures++; $display("FAIL reset_hit got=%b/%h exp=0/0000", hit0, hl0); end
        cmd_cmp(8'h00, 8'h00, 1'b0);
        checks++; if (hl0 !== 16'h0000 || hit0 !== 1'b0) begin failures++; $display("FAIL reset_all_invalid got=%h/%b exp=0000/0", hl0, hit0); end
    endtask

    task automatic test_compare();
        cmd_wr(4'd3, 1'b0, 8'h5A, 8'hFF, 1'b1, 1'b1);
        checks++; if (do0 !== 8'h00 || hl0 !== 16'h0000) begin failures++; $display("FAIL wr_outputs_hold got=%h/%h exp=00/0000", do0, hl0); end
        cmd_wr(4'd3, 1'b1, 8'hF0, 8'hFF, 1'b0, 1'b0);
        cmd_cmp(8'h50, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h0008 || hit0 !== 1'b1) begin failures++; $display("FAIL cmp_hit got=%h/%b exp=0008/1", hl0, hit0); end
`ifdef TCAM_MHIT_EN
        checks++; if (mhit0 !== 1'b0) begin failures++; $display("FAIL cmp_single_mhit got=%b exp=0", mhit0); end
`endif
        cmd_cmp(8'h60, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h0000 || hit0 !== 1'b0) begin failures++; $display("FAIL cmp_miss got=%h/%b exp=0000/0", hl0, hit0); end
    endtask

    task automatic test_bit_write();
        cmd_wr(4'd3, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b0);
        cmd_rd(4'd3, 1'b0, 1'b1);
        checks++; if (do0 !== 8'h50 || vbo0 !== 1'b1) begin failures++; $display("FAIL bitwrite_rd got=%h/%b exp=50/1", do0, vbo0); end
        cmd_rd(4'd3, 1'b1, 1'b0);
        checks++; if (do0 !== 8'hF0 || vbo0 !== 1'b0) begin failures++; $display("FAIL rd_care_novbe got=%h/%b exp=F0/0", do0, vbo0); end
    endtask

    task automatic test_multi_hit();
        cmd_wr(4'd1, 1'b0, 8'h50, 8'hFF, 1'b1, 1'b1);
        cmd_wr(4'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        cmd_cmp(8'h50, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h000A || hit0 !== 1'b1) begin failures++; $display("FAIL multi_hit got=%h/%b exp=000A/1", hl0, hit0); end
`ifdef TCAM_MHIT_EN
        checks++; if (mhit0 !== 1'b1) begin failures++; $display("FAIL multi_mhit got=%b exp=1", mhit0); end
`endif
        // CS=0 is a NOP: results hold despite a compare that would miss.
        idle(); cmp = 1; di = 8'hFF; mskb = 8'hFF; tick(); idle();
        checks++; if (hl0 !== 16'h000A || hit0 !== 1'b1) begin failures++; $display("FAIL cs_low_hold got=%h/%b exp=000A/1", hl0, hit0); end
        cmd_cmp(8'h50, 8'hF0, 1'b1);
        checks++; if (hl0 !== 16'h0000 || hit0 !== 1'b0) begin failures++; $display("FAIL cbe_miss got=%h/%b exp=0000/0", hl0, hit0); end
`ifdef TCAM_MHIT_EN
        checks++; if (mhit0 !== 1'b0) begin failures++; $display("FAIL cbe_mhit got=%b exp=0", mhit0); end
`endif
        // Entry 7 with care=0 matches any key; entries 1 and 3 miss 0x12.
        cmd_wr(4'd7, 1'b0, 8'hAA, 8'hFF, 1'b1, 1'b1);
        cmd_wr(4'd7, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
        cmd_cmp(8'h12, 8'hFF, 1'b0);
        checks++; if (hl0 !== 16'h0080 || hit0 !== 1'b1) begin failures++; $display("FAIL care_zero got=%h/%b exp=0080/1", hl0, hit0); end
    endtask

    task automatic test_flush();
        cmd_rd(4'd3, 1'b0, 1'b1);
        idle(); cs = 1; flush = 1; tick(); idle();
        checks++; if (do0 !== 8'h50 || vbo0 !== 1'b1 || hl0 !== 16'h0080) begin failures++; $display("FAIL flush_hold got=%h/%b/%h exp=50/1/0080", do0, vbo0, hl0); end
        cmd_cmp(8'h50, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h0000 || hit0 !== 1'b0) begin failures++; $display("FAIL flush_cmp got=%h/%b exp=0000/0", hl0, hit0); end
        cmd_rd(4'd3, 1'b0, 1'b1);
        checks++; if (do0 !== 8'h50 || vbo0 !== 1'b0) begin failures++; $display("FAIL flush_rd got=%h/%b exp=50/0", do0, vbo0); end
    endtask

    task automatic test_priority();
        cmd_rd(4'd3, 1'b1, 1'b1);
        checks++; if (do0 !== 8'hF0) begin failures++; $display("FAIL prio_setup got=%h exp=F0", do0); end
        idle();
        cs = 1; wr = 1; rd = 1; flush = 1; a = 4'd3; di = 8'hFF; mskb = 8'hFF; vbe = 1; vbi = 1;
        tick(); idle();
        checks++; if (do0 !== 8'hF0) begin failures++; $display("FAIL prio_do_hold got=%h exp=F0", do0); end
        cmd_rd(4'd3, 1'b0, 1'b1);
        checks++; if (do0 !== 8'h50 || vbo0 !== 1'b0) begin failures++; $display("FAIL prio_wr_dropped got=%h/%b exp=50/0", do0, vbo0); end
    endtask

    task automatic test_back_to_back();
        // Valid-only write then immediate compare: visible next cycle.
        cmd_wr(4'd3, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        cmd_cmp(8'h50, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h0008 || hit0 !== 1'b1) begin failures++; $display("FAIL b2b_cmp got=%h/%b exp=0008/1", hl0, hit0); end
        cmd_rd(4'd3, 1'b0, 1'b1);
        checks++; if (do1 !== 8'h50 || vbo1 !== 1'b1) begin failures++; $display("FAIL w12_rd3 got=%h/%b exp=50/1", do1, vbo1); end
        cmd_rd(4'hF, 1'b0, 1'b1);
        checks++; if (do1 !== 8'h00 || vbo1 !== 1'b0) begin failures++; $display("FAIL w12_rd_oor got=%h/%b exp=00/0", do1, vbo1); end
        checks++; if (hl1 !== 12'h008 || hit1 !== 1'b1) begin failures++; $display("FAIL w12_hit_hold got=%h/%b exp=008/1", hl1, hit1); end
    endtask

    task automatic test_reset_during_cmp();
        idle(); rst = 1; cs = 1; cmp = 1; di = 8'h50; mskb = 8'hF0;
        tick(); rst = 0; idle();
        checks++; if (hit0 !== 1'b0 || hl0 !== 16'h0000 || do0 !== 8'h00) begin failures++; $display("FAIL rst_cmp got=%b/%h/%h exp=0/0000/00", hit0, hl0, do0); end
        cmd_cmp(8'h50, 8'hF0, 1'b0);
        checks++; if (hl0 !== 16'h0000) begin failures++; $display("FAIL rst_clears_valid got=%h exp=0000", hl0); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_compare();
        test_bit_write();
        test_multi_hit();
        test_flush();
        test_priority();
        test_back_to_back();
        test_reset_during_cmp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tcam_array_model.md
Name: tcam_array_model

Overview:
- Cycle-accurate behavioural model of the 16x8 bit-write TCAM macro.
- It responds to the memory-side command bus that the TCAM controller drives: CS/WR/RD/CMP/FLUSH with data, mask, valid and address.
- Holds per-word data, care mask and valid bit; performs write, read, masked parallel compare and flush.
- Used as the simulation and FPGA stand-in for the hard macro beneath the controller.

Parameters:
- AddressSize, 4, width of A.
- Bits, 8, word width of DI/DO/MSKB.
- Words, 16, number of entries (must be ≤ 2**AddressSize).
- BankSize, 1, width of CBE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- CS  input  1  chip select; all commands ignored when 0.
- FLUSH  input  1  clear all valid bits.
- VBE  input  1  valid-bit enable for write.
- DCS  input  1  array select: 0 = data array, 1 = care array.
- WR  input  1  write command.
- RD  input  1  read command.
- CMP  input  1  compare command.
- DI  input  Bits  write data or search key.
- MSKB  input  Bits  write: per-bit write enable (1 = write); compare: key care (1 = compare bit).
- VBI  input  1  valid bit written when VBE=1.
- A  input  AddressSize  entry address for WR/RD.
- CBE  input  BankSize  bank compare disable; CBE[0]=1 forces a compare to miss.
- DO  output  Bits  read data.
- VBO  output  1  valid bit of the read entry.
- HIT  output  1  OR of HITLINE.
- HITLINE  output  Words  per-entry match vector; bit i = entry i.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst). All state updates occur on the rising edge of clk.
- Reset (rst=1):
  - Clears valid[] for all entries.
  - DO=0, VBO=0, HIT=0, HITLINE=0.
  - Data and care arrays retain their contents.
  - Reset overrides any command in the same cycle; a command in progress is dropped.
- Command decode, sampled at the edge when CS=1. Priority FLUSH > WR > RD > CMP; exactly one command executes per cycle. CS=0 is a NOP and all outputs hold.
- FLUSH:
  - valid[all] <= 0.
  - DO, VBO, HIT and HITLINE hold.
- WR, when A < Words:
  - Target array is data (DCS=0) or care (DCS=1).
  - arr[A][b] <= DI[b] for every b with MSKB[b]=1; other bits unchanged.
  - If VBE=1: valid[A] <= VBI.
  - Outputs hold. If A ≥ Words, the write is ignored.
- RD, 1-cycle latency (registered outputs):
  - DO <= DCS ? care[A] : data[A].
  - VBO <= VBE ? valid[A] : 0.
  - A ≥ Words gives DO=0, VBO=0.
  - HIT and HITLINE hold.
- CMP, 1-cycle latency:
  - HITLINE[i] <= valid[i] & ~CBE[0] & (&(~(MSKB & care[i]) | ~(data[i] ^ DI))).
  - HIT <= |(next HITLINE).
  - DO and VBO hold.
- Ordering: a write at cycle N is visible to a RD or CMP issued at cycle N+1. There is no same-cycle bypass, because only one command executes per cycle.
- HIT and HITLINE persist until the next CMP or reset. Multiple simultaneous hits are all reported in HITLINE.
- An entry with care=0 and valid=1 matches every key. An entry with valid=0 never matches.
- Combinational match reduction is Words x Bits; no pipelining beyond the output register.

Optional Feature:
- Macro: TCAM_MHIT_EN.
- Defined:
  - Adds output MHIT (1 bit), registered on CMP: 1 if two or more HITLINE bits are set next cycle.
  - Reset value 0; holds like HIT.
- Undefined: the port is absent; the rest of the behaviour is identical.

Test Plan:
- Reset with arrays preloaded -> DO=0, VBO=0, HIT=0, HITLINE=0x0000; CMP key 0x00 with MSKB 0x00 next cycle -> HITLINE=0x0000 (all invalid).
- WR A=3, DCS=0, DI=0x5A, MSKB=0xFF, VBE=1, VBI=1; then WR A=3, DCS=1, DI=0xF0, MSKB=0xFF, VBE=0; then CMP DI=0x50, MSKB=0xF0 -> next cycle HITLINE=0x0008, HIT=1. CMP DI=0x60 -> HITLINE=0x0000, HIT=0.
- Bit-write: WR A=3, DCS=0, DI=0x00, MSKB=0x0F -> RD A=3, DCS=0, VBE=1 next cycle returns DO=0x50, VBO=1.
- Two entries (1 and 3) matching key 0x50 -> HITLINE=0x000A, HIT=1; with TCAM_MHIT_EN also MHIT=1. Repeat with CBE=1 -> HITLINE=0x0000.
- FLUSH, then CMP DI=0x50, MSKB=0xF0 -> HITLINE=0x0000. RD A=3 with VBE=1 -> VBO=0 and DO=0x50 (data retained).
- WR, RD and FLUSH asserted together -> only the flush executes and DO holds. RD A=0xF with Words=12 -> DO=0, VBO=0. rst asserted during a CMP cycle -> HIT=0 next cycle.
